// File: rtl/eqed_misr_capture.sv
// rtl/eqed_misr_capture.sv - windowed input/output MISR capture with golden compare
// Compacts dut_in/dut_out into two MISRs over a start-triggered window of win_len cycles.
module eqed_misr_capture #(
  parameter int                IN_W     = 2,
  parameter int                OUT_W    = 3,
  parameter int                MISR_W   = 6,
  parameter logic [MISR_W-1:0] IN_POLY  = 6'b000011,
  parameter logic [MISR_W-1:0] OUT_POLY = 6'b000011,
  parameter logic [MISR_W-1:0] SEED     = 6'b000001,
  parameter int                CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  win_len,
  input  logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  input  logic [MISR_W-1:0] exp_in_sig,
  input  logic [MISR_W-1:0] exp_out_sig,
  output logic [MISR_W-1:0] in_sig,
  output logic [MISR_W-1:0] out_sig,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              aborted,
  output logic [CNT_W-1:0]  cyc_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   win_len_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               start_acc;
  logic [MISR_W-1:0]  in_ext;
  logic [MISR_W-1:0]  out_ext;

  function automatic logic [MISR_W-1:0] misr_next(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] poly,
    input logic [MISR_W-1:0] data
  );
    return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ data;
  endfunction

  assign in_ext    = MISR_W'(dut_in);
  assign out_ext   = MISR_W'(dut_out);
  assign cnt_inc   = cyc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  // start is only honoured outside an active window
  assign start_acc = start && (state != S_CAPTURE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = (win_len != '0) ? S_CAPTURE : S_DONE;
        end
      end
      S_CAPTURE: begin
        if (abort || (cnt_inc == win_len_q)) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == S_CAPTURE);
    done  = (state == S_DONE);
    match = done && !aborted && (in_sig == exp_in_sig) && (out_sig == exp_out_sig);
  end

  // abort wins over compaction, including the final one of the window
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_sig    <= SEED;
      out_sig   <= SEED;
      cyc_cnt   <= '0;
      aborted   <= 1'b0;
      win_len_q <= '0;
    end else if (start_acc) begin
      in_sig    <= SEED;
      out_sig   <= SEED;
      cyc_cnt   <= '0;
      aborted   <= 1'b0;
      win_len_q <= win_len;
    end else if (state == S_CAPTURE) begin
      if (abort) begin
        aborted <= 1'b1;
      end else begin
        in_sig  <= misr_next(in_sig, IN_POLY, in_ext);
        out_sig <= misr_next(out_sig, OUT_POLY, out_ext);
        cyc_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: doc/eqed_misr_capture.md
EQED_MISR_CAPTURE -- requirements
Module: eqed_misr_capture

Interface
REQ-001 Parameter IN_W, default 2: width of the design-under-check input bus.
REQ-002 Parameter OUT_W, default 3: width of the design-under-check output bus.
REQ-003 Parameter MISR_W, default 6: width of both signature registers; IN_W <= MISR_W and OUT_W <= MISR_W SHALL hold.
REQ-004 Parameter IN_POLY, default 6'b000011: feedback polynomial of the input MISR.
REQ-005 Parameter OUT_POLY, default 6'b000011: feedback polynomial of the output MISR.
REQ-006 Parameter SEED, default 6'b000001: reset/start value of both MISRs.
REQ-007 Parameter CNT_W, default 8: width of window length and cycle counter.
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 rst  in  1  synchronous, active-low reset.
REQ-010 start  in  1  pulse; begins a capture window.
REQ-011 abort  in  1  terminates a capture window early.
REQ-012 win_len  in  CNT_W  capture window length in cycles; sampled when start is accepted.
REQ-013 dut_in  in  IN_W  design-under-check inputs.
REQ-014 dut_out  in  OUT_W  design-under-check outputs.
REQ-015 exp_in_sig  in  MISR_W  golden input signature.
REQ-016 exp_out_sig  in  MISR_W  golden output signature.
REQ-017 in_sig  out  MISR_W  current input MISR value.
REQ-018 out_sig  out  MISR_W  current output MISR value.
REQ-019 busy  out  1  high in CAPTURE.
REQ-020 done  out  1  high in DONE.
REQ-021 match  out  1  high in DONE when in_sig==exp_in_sig and out_sig==exp_out_sig.
REQ-022 aborted  out  1  high in DONE when the window ended via abort.
REQ-023 cyc_cnt  out  CNT_W  cycles compacted in the current/last window.

Function
REQ-024 FSM states SHALL be IDLE, CAPTURE, DONE.
REQ-025 IDLE: start=1 with win_len!=0 -> CAPTURE; start=1 with win_len==0 -> DONE with seed signatures and cyc_cnt=0; otherwise stay.
REQ-026 On start acceptance, both MISRs SHALL load SEED, cyc_cnt SHALL load 0, aborted SHALL clear, and win_len SHALL be latched; no data is compacted on that edge.
REQ-027 Each CAPTURE cycle, each MISR SHALL update as next = (sig<<1 truncated to MISR_W) ^ (sig[MISR_W-1] ? POLY : 0) ^ zero-extended data, using dut_in for the input MISR and dut_out for the output MISR, and cyc_cnt SHALL increment.
REQ-028 CAPTURE -> DONE on the edge where cyc_cnt becomes the latched win_len; signature latency is therefore exactly win_len compaction edges after the start edge.
REQ-029 abort=1 in CAPTURE SHALL take effect on that edge: no compaction, MISRs and cyc_cnt hold, aborted=1, -> DONE.
REQ-030 abort has priority over the final compaction when both fall on the same edge.
REQ-031 start in CAPTURE SHALL be ignored.
REQ-032 DONE: MISRs and cyc_cnt hold; match SHALL be combinational on held signatures and golden inputs; match SHALL be 0 whenever aborted=1.
REQ-033 DONE: start=1 behaves as in IDLE (immediate restart); abort is ignored; otherwise stay in DONE.
REQ-034 cyc_cnt SHALL NOT wrap; win_len=2^CNT_W-1 is the maximum window.

Reset
REQ-035 rst=0 at a clock edge SHALL force IDLE, in_sig=out_sig=SEED, cyc_cnt=0, aborted=0, and busy=done=match=0, overriding start/abort.
REQ-036 Reset asserted mid-CAPTURE SHALL discard the window; no DONE is produced for it.

Verification (MISR_W=4, IN_W=OUT_W=4, POLYs=4'h3, SEED=4'h1)
REQ-037 Reset, start with win_len=4, dut_in=0 -> in_sig 1,2,4,8,3; done on the 4th edge after start; cyc_cnt=4.
REQ-038 Start with win_len=1, dut_out=4'hF -> out_sig=4'hD; with exp_out_sig=4'hD and exp_in_sig matching, match=1; with exp_out_sig=4'hC, match=0.
REQ-039 Start with win_len=5, abort on the 3rd CAPTURE cycle -> cyc_cnt=2, aborted=1, done=1, match=0, signatures frozen.
REQ-040 Start with win_len=0 -> done the next cycle, in_sig=out_sig=4'h1, cyc_cnt=0.
REQ-041 rst=0 on the 2nd CAPTURE cycle -> IDLE, signatures=4'h1, busy=done=0; then start in DONE restarts cleanly with aborted cleared.
